// File: rtl/job_arb_pkg.sv
// rtl/job_arb_pkg.sv - shared types, defaults and helpers for the job arbiter.
package job_arb_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int TO_W_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_FIN    = 2'd3
    } state_t;

    // Next round-robin position after idx, wrapping at n.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/job_arbiter_if.sv
// rtl/job_arbiter_if.sv - requester and engine handshake bundle for the job arbiter.
interface job_arbiter_if
    import job_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int TO_W  = TO_W_DEF
) ();

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] done;
    logic             err;
    logic             busy;
    logic             eng_start;
    logic             eng_busy;
    logic             eng_done;
    logic             eng_abort;
    logic [TO_W-1:0]  timeout_cfg;

    modport master (
        input  req, eng_busy, eng_done, timeout_cfg,
        output grant, done, err, busy, eng_start, eng_abort
    );

    modport slave (
        output req, eng_busy, eng_done, timeout_cfg,
        input  grant, done, err, busy, eng_start, eng_abort
    );

endinterface

// File: rtl/job_arbiter_rr_pick.sv
// rtl/job_arbiter_rr_pick.sv - combinational round-robin picker: first request at/after ptr.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_onehot,
    output logic             o_valid,
    output logic [PW-1:0]    o_index
);

    always_comb begin : pick
        int unsigned pos;
        pos      = 0;
        o_onehot = '0;
        o_valid  = 1'b0;
        o_index  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            pos = 32'(i_ptr) + i;
            if (pos >= N_REQ) pos = pos - N_REQ;
            if (!o_valid && i_req[pos[PW-1:0]]) begin
                o_valid               = 1'b1;
                o_index               = pos[PW-1:0];
                o_onehot[pos[PW-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/job_arbiter.sv
// rtl/job_arbiter.sv - round-robin sharing of one start/done job engine among N_REQ clients.
// Optional watchdog abort is built when JOB_TIMEOUT_EN is defined.
module job_arbiter
    import job_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int TO_W  = TO_W_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    job_arbiter_if.master bus
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t           r_state, w_state_nxt;
    logic [N_REQ-1:0] r_grant, w_grant_nxt;
    logic [N_REQ-1:0] r_done,  w_done_nxt;
    logic             r_start, w_start_nxt;
    logic             r_err,   w_err_nxt;
    logic             r_abort, w_abort_nxt;
    logic [PW-1:0]    r_ptr,   w_ptr_nxt;
    logic [PW-1:0]    r_owner, w_owner_nxt;

    logic [N_REQ-1:0] w_pick_oh;
    logic             w_pick_valid;
    logic [PW-1:0]    w_pick_idx;
    logic             w_terminal;
    logic             w_unused;

    rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
        .i_req    (bus.req),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_oh),
        .o_valid  (w_pick_valid),
        .o_index  (w_pick_idx)
    );

`ifdef JOB_TIMEOUT_EN
    logic [TO_W-1:0] r_wdog;

    // Counts WAIT cycles and sticks at all-ones so a long job can never alias a small limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog <= '0;
        end else if (r_state == ST_LAUNCH) begin
            r_wdog <= '0;
        end else if (r_state == ST_WAIT && r_wdog != '1) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    assign w_terminal = (bus.timeout_cfg != '0) && (r_wdog == bus.timeout_cfg - 1'b1);
`else
    assign w_terminal = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_done_nxt  = '0;
        w_start_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        w_abort_nxt = 1'b0;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_grant_nxt = w_pick_oh;
                    w_owner_nxt = w_pick_idx;
                    w_start_nxt = 1'b1;
                    w_state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                // A real completion beats a watchdog expiry in the same cycle.
                if (bus.eng_done) begin
                    w_done_nxt  = r_grant;
                    w_state_nxt = ST_FIN;
                end else if (w_terminal) begin
                    w_done_nxt  = r_grant;
                    w_err_nxt   = 1'b1;
                    w_abort_nxt = 1'b1;
                    w_state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                w_grant_nxt = '0;
                w_ptr_nxt   = PW'(wrap_inc(32'(r_owner), 32'(N_REQ)));
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_done  <= '0;
            r_start <= 1'b0;
            r_err   <= 1'b0;
            r_abort <= 1'b0;
            r_ptr   <= '0;
            r_owner <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_done  <= w_done_nxt;
            r_start <= w_start_nxt;
            r_err   <= w_err_nxt;
            r_abort <= w_abort_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    assign bus.grant     = r_grant;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.eng_abort = r_abort;
    assign bus.eng_start = r_start;
    assign bus.busy      = (r_state != ST_IDLE);

    // Engine busy is status only; timeout_cfg is idle when the watchdog is not built.
    assign w_unused = &{1'b0, bus.eng_busy, bus.timeout_cfg};

endmodule

// File: tb/tb_job_arbiter.sv
// tb/tb_job_arbiter.sv - randomized and directed bench for job_arbiter with a job-timeline model.
module tb_job_arbiter;
    import job_arb_pkg::*;

    localparam int N  = 4;
    localparam int TW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    job_arbiter_if #(.N_REQ(N), .TO_W(TW)) bus ();
    job_arbiter #(.N_REQ(N), .TO_W(TW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Job timeline model: owner, grant cycle, completion cycle.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_g     = 0;
    int m_fin   = -1;
    bit m_err   = 1'b0;
    int cyc     = 0;

    function automatic int first_from(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (p + k) % N;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        int w;
        if (!rst_n) begin
            m_owner = -1;
            m_ptr   = 0;
            m_fin   = -1;
            m_err   = 1'b0;
        end else begin
            if (m_owner < 0) begin
                m_owner = first_from(bus.req, m_ptr);
                if (m_owner >= 0) begin
                    m_g   = cyc + 1;
                    m_fin = -1;
                end
            end else if (cyc == m_fin) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end else if (cyc > m_g && m_fin < 0) begin
                w = cyc - m_g - 1;
                if (w > 255) w = 255;
                if (bus.eng_done) begin
                    m_fin = cyc + 1;
                    m_err = 1'b0;
                end
`ifdef JOB_TIMEOUT_EN
                else if (bus.timeout_cfg != 0 && w == int'(bus.timeout_cfg) - 1) begin
                    m_fin = cyc + 1;
                    m_err = 1'b1;
                end
`endif
            end
            cyc = cyc + 1;
        end
    end

    int g_log[$];
    int g_cyc[$];
    int d_cyc[$];
    bit d_err[$];

    always @(negedge clk) begin : cmp
        logic [N-1:0] eg, ed;
        bit es, fin;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        es  = (m_owner >= 0) && (cyc == m_g);
        fin = (m_owner >= 0) && (cyc == m_fin);
        ed  = fin ? eg : '0;
        chk("grant", bus.grant, eg);
        chk("done", bus.done, ed);
        chk("err", bus.err, fin && m_err);
        chk("eng_abort", bus.eng_abort, fin && m_err);
        chk("eng_start", bus.eng_start, es);
        chk("busy", bus.busy, m_owner >= 0);
        if (rst_n && bus.eng_start) begin
            for (int k = 0; k < N; k++) if (bus.grant[k]) g_log.push_back(k);
            g_cyc.push_back(cyc);
        end
        if (rst_n && bus.done != '0) begin
            d_cyc.push_back(cyc);
            d_err.push_back(bus.err);
        end
    end

    // Engine emulation: eng_done eng_lat cycles after start (0 = never), plus kicks and noise.
    int eng_lat = 5;
    int eng_cnt = 0;
    bit kick    = 1'b0;
    bit spur_on = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) eng_cnt = 0;
        else if (bus.eng_start && eng_lat > 0) eng_cnt = eng_lat;
    end

    always @(posedge clk) begin : eng_drv
        bit p;
        #1;
        p = 1'b0;
        if (eng_cnt > 0) begin
            eng_cnt = eng_cnt - 1;
            if (eng_cnt == 0) p = 1'b1;
        end
        if (kick) begin
            p    = 1'b1;
            kick = 1'b0;
        end
        if (spur_on && $urandom_range(0, 9) == 0) p = 1'b1;
        bus.eng_done = p;
        bus.eng_busy = 1'($urandom_range(0, 1));
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_grants(input int target, input string name);
        int k = 0;
        while (g_log.size() < target && k < 200) begin
            step();
            k++;
        end
        chk(name, g_log.size(), target);
    endtask

    task automatic wait_dones(input int target, input string name);
        int k = 0;
        while (d_cyc.size() < target && k < 200) begin
            step();
            k++;
        end
        chk(name, d_cyc.size(), target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int t0, nd, ng;
        int exp_seq[5];
        exp_seq = '{3, 0, 1, 2, 3};
        bus.req         = '0;
        bus.eng_done    = 1'b0;
        bus.eng_busy    = 1'b0;
        bus.timeout_cfg = '0;
        repeat (3) @(negedge clk);
        chk("rst_grant", bus.grant, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_start", bus.eng_start, 0);
        #1 rst_n = 1'b1;

        // Single requester 2, engine answers 5 cycles after start.
        eng_lat = 5;
        step();
        t0 = cyc;
        bus.req = 4'b0100;
        wait_dones(1, "t1_done_arrives");
        chk("t1_owner", g_log[$], 2);
        chk("t1_grant_lat", g_cyc[$] - t0, 1);
        chk("t1_done_lat", d_cyc[$] - g_cyc[$], 6);
        chk("t1_err", d_err[$], 0);
        bus.req = '0;
        step();
        chk("t1_busy_after", bus.busy, 0);

        // All requesting, 3-cycle jobs; pointer continues after owner 2.
        eng_lat = 3;
        ng = g_log.size();
        bus.req = 4'b1111;
        wait_grants(ng + 5, "t2_grants");
        bus.req = '0;
        for (int i = 0; i < 5; i++) chk("t2_order", g_log[ng + i], exp_seq[i]);
        for (int i = 0; i < 4; i++) chk("t2_gap", g_cyc[ng + i + 1] - g_cyc[ng + i], 6);
        wait_dones(1 + 5, "t4_dropped_owner_done");

        // Wrap: 3 served, then 0 and 3 pending -> 0 first.
        bus.req = 4'b1000;
        ng = g_log.size();
        wait_grants(ng + 1, "t3_first");
        chk("t3_owner3", g_log[$], 3);
        bus.req = 4'b1001;
        wait_grants(ng + 2, "t3_second");
        chk("t3_wrap_to0", g_log[$], 0);
        wait_grants(ng + 3, "t3_third");
        chk("t3_then3", g_log[$], 3);
        bus.req = '0;
        wait_dones(d_cyc.size() + 1, "t3_done");

        // Spurious engine completion while idle.
        step();
        kick = 1'b1;
        ng = g_log.size();
        repeat (3) step();
        chk("t4_idle_busy", bus.busy, 0);
        chk("t4_no_grant", g_log.size(), ng);

`ifdef JOB_TIMEOUT_EN
        bus.timeout_cfg = 4;
        eng_lat = 0;
        bus.req = 4'b0010;
        wait_grants(g_log.size() + 1, "t5_to_grant");
        wait_dones(d_cyc.size() + 1, "t5_to_done");
        chk("t5_to_lat", d_cyc[$] - g_cyc[$], 5);
        chk("t5_to_err", d_err[$], 1);
        bus.req = '0;
        eng_lat = 4;
        step();
        bus.req = 4'b0010;
        wait_grants(g_log.size() + 1, "t5_tie_grant");
        wait_dones(d_cyc.size() + 1, "t5_tie_done");
        chk("t5_tie_lat", d_cyc[$] - g_cyc[$], 5);
        chk("t5_tie_err", d_err[$], 0);
        bus.req = '0;
        bus.timeout_cfg = 0;
        eng_lat = 0;
        step();
`else
        bus.timeout_cfg = 4;
        eng_lat = 0;
`endif
        bus.req = 4'b0010;
        wait_grants(g_log.size() + 1, "t5_hold_grant");
        nd = d_cyc.size();
        repeat (40) step();
        chk("t5_waits", d_cyc.size(), nd);
        chk("t5_still_busy", bus.busy, 1);
        kick = 1'b1;
        wait_dones(nd + 1, "t5_kick_done");
        chk("t5_kick_err", d_err[$], 0);
        bus.req = '0;
        bus.timeout_cfg = 0;

        // Asynchronous reset in WAIT.
        step();
        bus.req = 4'b0100;
        wait_grants(g_log.size() + 1, "t6_grant");
        step();
        rst_n = 1'b0;
        #1;
        chk("t6_async_grant", bus.grant, 0);
        chk("t6_async_busy", bus.busy, 0);
        nd = d_cyc.size();
        bus.req = '0;
        step();
        step();
        rst_n = 1'b1;
        repeat (10) step();
        chk("t6_no_done", d_cyc.size(), nd);

        // Randomized traffic checked cycle by cycle against the model.
        spur_on = 1'b1;
        eng_lat = 3;
        repeat (1500) begin
            step();
            if ($urandom_range(0, 3) == 0) bus.req = N'($urandom);
            if ($urandom_range(0, 15) == 0) eng_lat = $urandom_range(0, 6);
            if ($urandom_range(0, 15) == 0) bus.timeout_cfg = TW'($urandom_range(0, 6));
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
        end
        spur_on = 1'b0;
        bus.req = '0;
        kick = 1'b1;
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
